dadda_pipe_adder: RTL and testbench

//  Pipelined N-operand, W-bit multi-operand adder for the CFA datapath; the next generation of the 5x12 Dadda summer.
//  A Dadda tree reduces the operands to two rows, one register stage per reduction level.
//  A registered final carry-propagate add follows the tree.

---
 rtl/dadda_pipe_adder_pkg.sv | 38 +++
 rtl/dadda_pipe_adder_if.sv | 38 +++
 rtl/dadda_pipe_adder_csa_row.sv | 23 ++
 rtl/dadda_pipe_adder.sv | 134 +++++++++++++
 tb/tb_dadda_pipe_adder.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dadda_pipe_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : cfa_adder_pkg                                                   |
// | Purpose  : Shared types and elaboration-time helpers for the pipelined     |
// |            Dadda multi-operand adder (height sequence, level count, the    |
// |            per-stage flow tag).                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package cfa_adder_pkg;

  localparam int DADDA_N = 7;
  localparam int DADDA_H [DADDA_N] = '{2, 3, 4, 6, 9, 13, 19};

  // Dadda target height d_j. Indices past the table return 0 so that a bad
  // index shows up as an obviously broken elaboration.
  function automatic int dadda_height(input int j);
    if (j < 0 || j >= DADDA_N) return 0;
    return DADDA_H[j];
  endfunction

  // Number of reduction levels: every Dadda height strictly below n.
  function automatic int dadda_levels(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < DADDA_N; i++) begin
      if (DADDA_H[i] < n) cnt++;
    end
    return cnt;
  endfunction

  // Control tag that travels with every bundle through the pipe.
  typedef struct packed {
    logic valid;
    logic is_signed;
  } flow_t;

endpackage
`default_nettype wire

// File: rtl/dadda_pipe_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : dadda_pipe_adder_if                                            |
// | Purpose   : Operand-in / sum-out handshake bundle of dadda_pipe_adder.     |
// |   in_valid/in_ready  operand bundle handshake                              |
// |   in_signed          two's-complement mode of the bundle                   |
// |   in_ops             N_OPS packed operands, operand k = in_ops[k*W +: W]   |
// |   out_valid/out_ready result handshake                                     |
// |   out_sum            exact OW-bit sum, out_signed mode of that result      |
// |   master : the producer/consumer side, slave : the adder                   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface dadda_pipe_adder_if #(
  parameter int N_OPS = 5,
  parameter int W     = 12
) ();
  localparam int OW = W + $clog2(N_OPS);

  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [N_OPS*W-1:0] in_ops;
  logic               out_valid;
  logic               out_ready;
  logic [OW-1:0]      out_sum;
  logic               out_signed;

  modport master (
    output in_valid, in_signed, in_ops, out_ready,
    input  in_ready, out_valid, out_sum, out_signed
  );

  modport slave (
    input  in_valid, in_signed, in_ops, out_ready,
    output in_ready, out_valid, out_sum, out_signed
  );
endinterface
`default_nettype wire

// File: rtl/dadda_pipe_adder_csa_row.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : csa_row                                                         |
// | Purpose  : Combinational row of N_FA independent full adders (3:2          |
// |            compressors) for one column of a Dadda reduction level.         |
// |   i_a, i_b, i_c  three bits of equal weight per adder                      |
// |   o_s            sum bits, same weight                                     |
// |   o_co           carry bits, next-higher weight                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module csa_row #(
  parameter int N_FA = 1
) (
  input  logic [N_FA-1:0] i_a,
  input  logic [N_FA-1:0] i_b,
  input  logic [N_FA-1:0] i_c,
  output logic [N_FA-1:0] o_s,
  output logic [N_FA-1:0] o_co
);
  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule
`default_nettype wire

// File: rtl/dadda_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dadda_pipe_adder                                                |
// | Purpose  : Pipelined N_OPS x W multi-operand adder. Operands are extended  |
// |            to OW bits, reduced by a Dadda tree (one register per level)    |
// |            to two rows, then summed by a registered carry-propagate add.   |
// |            Valid/ready handshake with per-stage valid bits and collapsing  |
// |            bubbles.                                                        |
// |   clk, rst_n  clock, synchronous active-low reset                          |
// |   bus         dadda_pipe_adder_if slave port                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dadda_pipe_adder
  import cfa_adder_pkg::*;
#(
  parameter int N_OPS = 5,
  parameter int W     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  dadda_pipe_adder_if.slave bus
);
  localparam int OW     = W + $clog2(N_OPS);
  localparam int LEVELS = dadda_levels(N_OPS);
  localparam int LAT    = LEVELS + 1;

  flow_t         r_flow [1:LAT];  // tag held by stage s
  flow_t         w_fin  [1:LAT];  // tag offered to stage s
  logic [LAT:1]  w_rdy;
  logic [OW-1:0] w_ext  [N_OPS];
  logic [OW-1:0] r_sum;

  always_comb begin
    w_fin[1].valid     = bus.in_valid;
    w_fin[1].is_signed = bus.in_valid & bus.in_signed;
    for (int s = 2; s <= LAT; s++) w_fin[s] = r_flow[s-1];
  end

  // Stage s may load whenever any stage from s to the output is empty, or
  // the consumer takes the result: the unrolled form of !v[s] | ready[s+1].
  always_comb begin
    for (int s = 1; s <= LAT; s++) begin
      w_rdy[s] = bus.out_ready;
      for (int k = s; k <= LAT; k++) begin
        if (!r_flow[k].valid) w_rdy[s] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 1; s <= LAT; s++) r_flow[s] <= '0;
    end else begin
      for (int s = 1; s <= LAT; s++) begin
        if (w_rdy[s]) r_flow[s] <= w_fin[s];
      end
    end
  end

  for (genvar k = 0; k < N_OPS; k++) begin : g_ext
    logic [W-1:0] w_op;
    assign w_op     = bus.in_ops[k*W +: W];
    assign w_ext[k] = {{(OW-W){bus.in_signed & w_op[W-1]}}, w_op};
  end

  // Every column of every row carries the same height, so each level uses
  // K = H_IN - H_OUT full adders per column: sums stay, carries move up one
  // column, the rest pass straight through. Carries out of the MSB column
  // are dropped; the exact sum always fits in OW bits.
  for (genvar s = 1; s <= LEVELS; s++) begin : g_stage
    localparam int H_IN  = (s == 1) ? N_OPS : dadda_height(LEVELS - s + 1);
    localparam int H_OUT = dadda_height(LEVELS - s);
    localparam int K     = H_IN - H_OUT;

    logic [OW-1:0] w_in  [H_IN];
    logic [OW-1:0] w_out [H_OUT];
    logic [OW-1:0] r_row [H_OUT];
    logic [K-1:0]  w_co  [OW-1];

    if (s == 1) begin : g_src_ops
      assign w_in = w_ext;
    end else begin : g_src_prev
      assign w_in = g_stage[s-1].r_row;
    end

    for (genvar c = 0; c < OW; c++) begin : g_col
      logic [K-1:0] w_a, w_b, w_c, w_s;
      for (genvar i = 0; i < K; i++) begin : g_fa
        assign w_a[i]      = w_in[3*i][c];
        assign w_b[i]      = w_in[3*i+1][c];
        assign w_c[i]      = w_in[3*i+2][c];
        assign w_out[i][c] = w_s[i];
        if (c == 0) begin : g_cin0
          assign w_out[K+i][c] = 1'b0;
        end else begin : g_cin
          assign w_out[K+i][c] = w_co[c-1][i];
        end
      end
      for (genvar j = 0; j < H_IN - 3*K; j++) begin : g_pass
        assign w_out[2*K+j][c] = w_in[3*K+j][c];
      end
      if (c == OW-1) begin : g_msb
        assign w_s = w_a ^ w_b ^ w_c;
      end else begin : g_csa
        csa_row #(.N_FA(K)) u_csa (
          .i_a  (w_a),
          .i_b  (w_b),
          .i_c  (w_c),
          .o_s  (w_s),
          .o_co (w_co[c])
        );
      end
    end

    always_ff @(posedge clk) begin
      if (w_rdy[s] && w_fin[s].valid) r_row <= w_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_rdy[LAT] && w_fin[LAT].valid) begin
      r_sum <= g_stage[LEVELS].r_row[0] + g_stage[LEVELS].r_row[1];
    end
  end

  assign bus.in_ready   = w_rdy[1];
  assign bus.out_valid  = r_flow[LAT].valid;
  assign bus.out_signed = r_flow[LAT].is_signed;
  assign bus.out_sum    = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_dadda_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dadda_pipe_adder                                             |
// | Purpose  : Self-checking bench for dadda_pipe_adder: directed cases on the |
// |            5x12 configuration plus randomized traffic on 3x32, 7x4 and     |
// |            16x32 instances, all scored against an integer-sum model.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dadda_pipe_adder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  bit   go_rnd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer sum of the operands interpreted in the bundle's
  // mode, reduced modulo 2^(W+clog2(N)).
  function automatic logic [63:0] ref_sum(input int n, input int w, input logic [511:0] ops, input bit sg);
    longint acc;
    longint v;
    acc = 0;
    for (int k = 0; k < n; k++) begin
      v = 0;
      for (int b = 0; b < w; b++) if (ops[k*w+b]) v = v + (longint'(1) << b);
      if (sg && ops[k*w+w-1]) v = v - (longint'(1) << w);
      acc = acc + v;
    end
    return 64'(acc) & ((64'd1 << (w + $clog2(n))) - 64'd1);
  endfunction

  // ---------------- main 5x12 instance ----------------
  dadda_pipe_adder_if #(.N_OPS(5), .W(12)) b0 ();
  dadda_pipe_adder #(.N_OPS(5), .W(12)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  logic [63:0] q0_sum [$];
  bit          q0_sg  [$];
  int          n_sent;

  always @(negedge clk) begin
    if (!rst_n) begin
      q0_sum.delete();
      q0_sg.delete();
    end else begin
      if (b0.out_valid && b0.out_ready) begin
        if (q0_sum.size() == 0) check_val("stale_out", 1, 0);
        else begin
          check_val("sb_sum", 64'(b0.out_sum), q0_sum.pop_front());
          check_val("sb_sgn", 64'(b0.out_signed), 64'(q0_sg.pop_front()));
        end
      end
      if (b0.in_valid && b0.in_ready) begin
        q0_sum.push_back(ref_sum(5, 12, 512'(b0.in_ops), b0.in_signed));
        q0_sg.push_back(b0.in_signed);
      end
    end
  end

  task automatic send0(input logic [59:0] ops, input bit sg);
    bit ok;
    ok = 1'b0;
    b0.in_ops    = ops;
    b0.in_signed = sg;
    b0.in_valid  = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = b0.in_ready;
      @(posedge clk);
      #1;
    end
    b0.in_valid = 1'b0;
    if (ok) n_sent++;
    else check_val("send_timeout", 0, 1);
  endtask

  task automatic wait_valid0();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      seen = b0.out_valid;
    end
    if (!seen) check_val("valid_timeout", 0, 1);
  endtask

  task automatic drain0();
    for (int c = 0; c < 200 && q0_sum.size() != 0; c++) @(negedge clk);
    check_val("drain", 64'(q0_sum.size()), 0);
  endtask

  // ---------------- randomized extra configurations ----------------
  function automatic int cfg_n(input int i);
    case (i)
      0:       return 3;
      1:       return 7;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_w(input int i);
    case (i)
      1:       return 4;
      default: return 32;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int GN = cfg_n(g);
    localparam int GW = cfg_w(g);

    dadda_pipe_adder_if #(.N_OPS(GN), .W(GW)) g_if ();
    dadda_pipe_adder #(.N_OPS(GN), .W(GW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (g_if)
    );

    logic [63:0] q_sum [$];
    bit          q_sg  [$];
    bit          done;

    always @(negedge clk) begin
      if (!rst_n) begin
        q_sum.delete();
        q_sg.delete();
      end else begin
        if (g_if.out_valid && g_if.out_ready) begin
          if (q_sum.size() == 0) check_val("rnd_stale", 1, 0);
          else begin
            check_val("rnd_sum", 64'(g_if.out_sum), q_sum.pop_front());
            check_val("rnd_sgn", 64'(g_if.out_signed), 64'(q_sg.pop_front()));
          end
        end
        if (g_if.in_valid && g_if.in_ready) begin
          q_sum.push_back(ref_sum(GN, GW, 512'(g_if.in_ops), g_if.in_signed));
          q_sg.push_back(g_if.in_signed);
        end
      end
    end

    initial begin
      g_if.in_valid  = 1'b0;
      g_if.in_signed = 1'b0;
      g_if.in_ops    = '0;
      done           = 1'b0;
      wait (go_rnd);
      @(posedge clk);
      #1;
      for (int t = 0; t < 40; t++) begin
        logic [GN*GW-1:0] ops;
        logic [GW-1:0]    p;
        bit               sg;
        bit               ok;
        sg = 1'(($urandom >> 3) & 1);
        for (int k = 0; k < GN; k++) begin
          case (t)
            0:       begin p = '1;                          sg = 1'b0; end
            1:       begin p = {1'b1, {(GW-1){1'b0}}};      sg = 1'b1; end
            2:       begin p = {1'b0, {(GW-1){1'b1}}};      sg = 1'b1; end
            3:       begin p = '1;                          sg = 1'b1; end
            default: p = GW'($urandom);
          endcase
          ops[k*GW +: GW] = p;
        end
        g_if.in_ops    = ops;
        g_if.in_signed = sg;
        g_if.in_valid  = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
          @(negedge clk);
          ok = g_if.in_ready;
          @(posedge clk);
          #1;
        end
        g_if.in_valid = 1'b0;
        if (!ok) check_val("rnd_send_timeout", 0, 1);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      for (int c = 0; c < 400 && q_sum.size() != 0; c++) @(negedge clk);
      check_val("rnd_drain", 64'(q_sum.size()), 0);
      done = 1'b1;
    end

    initial begin
      g_if.out_ready = 1'b0;
      wait (go_rnd);
      while (!done) begin
        @(posedge clk);
        #1;
        g_if.out_ready = ($urandom_range(0, 3) != 0);
      end
      g_if.out_ready = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          n;
    int          base;
    bit          all_rdy;
    bit          stale;
    bit          rnd0_done;
    logic [14:0] s0;

    n_checks      = 0;
    n_errors      = 0;
    n_sent        = 0;
    go_rnd        = 1'b0;
    rnd0_done     = 1'b0;
    b0.in_valid   = 1'b0;
    b0.in_signed  = 1'b0;
    b0.in_ops     = '0;
    b0.out_ready  = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready",   64'(b0.in_ready),   1);
    check_val("rst_out_valid",  64'(b0.out_valid),  0);
    check_val("rst_out_sum",    64'(b0.out_sum),    0);
    check_val("rst_out_signed", 64'(b0.out_signed), 0);
    @(posedge clk);
    #1;

    // Bundle 1: unsigned maximum, latency measured from the accepting edge.
    b0.out_ready = 1'b1;
    send0({5{12'hFFF}}, 1'b0);
    n = 1;
    while (!b0.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("latency",     64'(n), 4);
    check_val("max_u_sum",   64'(b0.out_sum), 64'd20475);
    check_val("max_u_sgn",   64'(b0.out_signed), 0);

    // Bundle 2: signed minimum.
    send0({5{12'h800}}, 1'b1);
    wait_valid0();
    check_val("min_s_sum", 64'(b0.out_sum), 64'h5800);
    check_val("min_s_sgn", 64'(b0.out_signed), 1);
    @(posedge clk);
    #1;

    // Bundle 3: back-to-back, mixed mode.
    send0({12'd5, 12'd4, 12'd3, 12'd2, 12'd1}, 1'b0);
    send0({12'd0, 12'd0, 12'd0, 12'hFFF, 12'd2047}, 1'b1);
    wait_valid0();
    check_val("b2b_first",  64'(b0.out_sum), 64'd15);
    @(negedge clk);
    check_val("b2b_valid2", 64'(b0.out_valid), 1);
    check_val("b2b_second", 64'(b0.out_sum), 64'd2046);
    @(posedge clk);
    #1;
    drain0();
    @(posedge clk);
    #1;

    // Backpressure: six bundles against a stalled sink.
    b0.out_ready = 1'b0;
    base = n_sent;
    fork
      begin
        for (int i = 0; i < 6; i++) send0(60'({$urandom, $urandom}), 1'(i & 1));
      end
      begin
        repeat (8) @(negedge clk);
        check_val("bp_in_ready", 64'(b0.in_ready), 0);
        check_val("bp_accepted", 64'(n_sent - base), 4);
        check_val("bp_valid",    64'(b0.out_valid), 1);
        s0 = b0.out_sum;
        repeat (2) @(negedge clk);
        check_val("bp_hold", 64'(b0.out_sum), 64'(s0));
        @(posedge clk);
        #1;
        b0.out_ready = 1'b1;
      end
    join
    drain0();
    @(posedge clk);
    #1;

    // Bubble collapse: bundle, two idle cycles, bundle, sink stalled.
    b0.out_ready = 1'b0;
    base = n_sent;
    all_rdy = 1'b1;
    fork
      begin
        send0(60'({$urandom, $urandom}), 1'b0);
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        send0(60'({$urandom, $urandom}), 1'b1);
      end
      begin
        repeat (7) begin
          @(negedge clk);
          if (!b0.in_ready) all_rdy = 1'b0;
        end
      end
    join
    check_val("bubble_ready",  64'(all_rdy), 1);
    check_val("bubble_sent",   64'(n_sent - base), 2);
    b0.out_ready = 1'b1;
    drain0();
    @(posedge clk);
    #1;

    // Reset with three bundles in flight.
    send0({5{12'h123}}, 1'b0);
    send0({5{12'h456}}, 1'b1);
    send0({5{12'h789}}, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("mid_rst_valid", 64'(b0.out_valid), 0);
    check_val("mid_rst_ready", 64'(b0.in_ready), 1);
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (b0.out_valid) stale = 1'b1;
    end
    check_val("mid_rst_stale", 64'(stale), 0);
    @(posedge clk);
    #1;
    send0({12'd100, 12'd200, 12'd300, 12'd400, 12'd500}, 1'b0);
    n = 1;
    while (!b0.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("post_rst_lat", 64'(n), 4);
    check_val("post_rst_sum", 64'(b0.out_sum), 64'd1500);
    drain0();

    // Random traffic on the main instance with a random sink.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          send0(60'({$urandom, $urandom}), 1'($urandom & 1));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rnd0_done = 1'b1;
      end
      begin
        while (!rnd0_done) begin
          @(posedge clk);
          #1;
          b0.out_ready = 1'($urandom & 1);
        end
      end
    join
    b0.out_ready = 1'b1;
    drain0();

    go_rnd = 1'b1;
    wait (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
